hex_bcd_display: RTL and testbench
==================================

# hex_bcd_display

Sequential binary-to-decimal display stage sitting directly downstream of the CPU's memory-mapped hex output register, in place of the direct hex-digit decode. On a load strobe it converts a 32-bit unsigned value to 8 BCD digits using iterative double-dabble, then drives the eight active-low seven-segment outputs (HEX0..HEX7) from registered display state. Values above 99,999,999 are flagged as overflow and shown as dashes.

## Interface
- BLANK_LZ, 1, when 1 leading zero digits are blanked (HEX0 always shown); when 0 all eight digits are shown.
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- value  in  32  unsigned binary value from the CPU io register.
- load  in  1  single-cycle strobe; capture `value` and convert.
- HEX0..HEX7  out  7 each  active-low segments, bit0=a … bit6=g; HEX0 is the least significant digit.
- busy  out  1  conversion in progress.
- ovf  out  1  last completed conversion exceeded 99,999,999.

## Operation
- States: IDLE, SHIFT, UPDATE.
- IDLE: if `load` is asserted, capture `value` into the 32-bit shift register, clear the 32-bit BCD register, clear the working overflow flag, set count=0, and go to SHIFT.
- SHIFT (32 cycles):
  - Each cycle, every BCD digit ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - If the bit shifted out of digit 7's MSB is 1, set the working overflow flag (sticky for this conversion).
  - count increments; after the 32nd shift, go to UPDATE.
- UPDATE (1 cycle):
  - Latch the BCD digits and the working overflow flag into the display registers; `ovf` updates.
  - If `load` is asserted this cycle, start a new conversion with the current `value`.
  - Otherwise, if the pending flag is set, start a new conversion from the pending register and clear the flag.
  - Otherwise go to IDLE.
- `load` while in SHIFT: copy `value` into the pending register and set the pending flag. A later load overwrites the pending value, so only the newest is kept. A load is never dropped silently; only superseded.
- Segment encoding, active-low, digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank = 7F. Dash = 3F.
- Display rules:
  - ovf=1: all eight HEX show dash.
  - BLANK_LZ=1: digits above the most significant nonzero digit show 7F.
  - Value 0: HEX0 shows 40.
- Digit values 10-15 cannot occur after a valid double-dabble; if one does, the digit shows blank.

## Timing
- Reset (async assert, any state): state=IDLE, all HEX=7F, busy=0, ovf=0, pending cleared, shift, BCD and count registers cleared. A conversion in progress is abandoned; no partial result is displayed.
- Load sampled at edge E0 → busy=1 after E0. Shifts happen at E1..E32. Display registers, HEX and ovf update at E33.
- busy falls after E33 unless a new conversion starts. Conversion latency is 33 cycles from the load edge.
- HEX outputs come straight from registers (no combinational path from `value`) and hold between conversions.
- Back-to-back conversions: the load sampled at E33 restarts with no IDLE cycle; busy stays 1.

## Test plan
- Reset low mid-SHIFT (cycle 10 of a conversion of 12345), then release → all HEX=7F, busy=0, ovf=0. A following load of 7 gives HEX0=78 and the rest 7F.
- load value=12345 (BLANK_LZ=1) → 33 cycles later: HEX0=12, HEX1=19, HEX2=30, HEX3=24, HEX4=79, HEX5..7=7F, ovf=0, busy falls.
- load value=0 → HEX0=40, HEX1..7=7F. With BLANK_LZ=0 → all eight HEX=40.
- load value=99999999 → all HEX=10, ovf=0. Then load 100000000 → all HEX=3F, ovf=1.
- load value=32'h88000000 → ovf=1, all HEX=3F, 33 cycles after the load.
- load 5, then load 42 and load 9 during SHIFT → first result HEX0=12 at E33. The second conversion starts at E33 with no IDLE cycle and busy stays 1. Final display is HEX0=10 (value 9) with HEX1..7 blank; 42 is superseded.

Source files
------------

// File: rtl/hex_bcd_display.sv
// rtl/hex_bcd_display.sv - iterative binary-to-BCD converter driving eight seven-segment digits
//
// Purpose: on a load strobe, convert a 32-bit unsigned value to eight BCD
// digits with shift-and-add-3 (one bit per clock), then latch the active-low
// segment patterns into output registers. Values above 99,999,999 show dashes.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   BLANK_LZ   in   1 = blank leading zero digits (HEX0 always shown)
//   value      in   32-bit unsigned value to convert
//   load       in   single-cycle strobe, capture value and convert
//   HEX0..HEX7 out  active-low segments, bit0=a .. bit6=g, HEX0 least significant
//   busy       out  conversion in progress
//   ovf        out  last completed conversion exceeded 99,999,999

module hex_bcd_display (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        BLANK_LZ,
   input  logic [31:0] value,
   input  logic        load,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic [6:0]  HEX6,
   output logic [6:0]  HEX7,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   state_t      state_q, state_d;
   logic [31:0] bin_q, bin_d;
   logic [31:0] bcd_q, bcd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        wovf_q, wovf_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_val_q, pend_val_d;
   logic [55:0] hex_q, hex_d;
   logic        ovf_q, ovf_d;

   logic [31:0] adj;
   logic [55:0] disp_seg;
   logic [7:0]  blank;
   logic        lead;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;   // 10-15 never valid BCD
      endcase
   endfunction

   // Add-3 correction applied to every digit before the shift.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Segment image of the finished conversion; a digit is blanked when it and
   // every digit above it are zero.
   always_comb begin
      disp_seg = '0;
      blank    = '0;
      lead     = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         lead     = lead & (bcd_q[4*i +: 4] == 4'd0);
         blank[i] = BLANK_LZ & lead;
      end
      for (int i = 0; i < 8; i++) begin
         if (wovf_q) begin
            disp_seg[7*i +: 7] = SEG_DASH;
         end else if (blank[i]) begin
            disp_seg[7*i +: 7] = SEG_BLANK;
         end else begin
            disp_seg[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      wovf_d     = wovf_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      hex_d      = hex_q;
      ovf_d      = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (load) begin
               bin_d   = value;
               bcd_d   = '0;
               wovf_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            bcd_d = {adj[30:0], bin_q[31]};
            bin_d = {bin_q[30:0], 1'b0};
            if (adj[31]) begin
               wovf_d = 1'b1;
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_UPDATE;
            end
            // Newest load wins; it is replayed after this conversion finishes.
            if (load) begin
               pend_val_d = value;
               pend_d     = 1'b1;
            end
         end

         S_UPDATE: begin
            hex_d = disp_seg;
            ovf_d = wovf_q;
            if (load || pend_q) begin
               // A load arriving now is newer than anything pending.
               bin_d   = load ? value : pend_val_q;
               pend_d  = 1'b0;
               bcd_d   = '0;
               wovf_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         wovf_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         hex_q      <= {8{SEG_BLANK}};
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         wovf_q     <= wovf_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         hex_q      <= hex_d;
         ovf_q      <= ovf_d;
      end
   end

   assign HEX0 = hex_q[6:0];
   assign HEX1 = hex_q[13:7];
   assign HEX2 = hex_q[20:14];
   assign HEX3 = hex_q[27:21];
   assign HEX4 = hex_q[34:28];
   assign HEX5 = hex_q[41:35];
   assign HEX6 = hex_q[48:42];
   assign HEX7 = hex_q[55:49];
   assign busy = (state_q != S_IDLE);
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_hex_bcd_display.sv
// tb/tb_hex_bcd_display.sv - self-checking bench for hex_bcd_display

module tb_hex_bcd_display;

   logic        CLOCK_50;
   logic        rst_n;
   logic        BLANK_LZ;
   logic [31:0] value;
   logic        load;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
   logic        busy;
   logic        ovf;

   int vectors     = 0;
   int miscompares = 0;

   hex_bcd_display dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .BLANK_LZ (BLANK_LZ),
      .value    (value),
      .load     (load),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5),
      .HEX6     (HEX6),
      .HEX7     (HEX7),
      .busy     (busy),
      .ovf      (ovf)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tbl[d];
   endfunction

   // Expected {HEX7..HEX0} for a completed conversion of v.
   function automatic logic [55:0] model_hex(input logic [31:0] v, input logic blz);
      logic [55:0] r;
      int          dig [8];
      int          msd;
      longint unsigned p;
      r   = '0;
      msd = 0;
      p   = 1;
      for (int i = 0; i < 8; i++) begin
         dig[i] = int'((longint'(v) / p) % 10);
         if (dig[i] != 0) msd = i;
         p = p * 10;
      end
      for (int i = 0; i < 8; i++) begin
         if (v > 32'd99999999)      r[7*i +: 7] = 7'h3F;
         else if (blz && i > msd)   r[7*i +: 7] = 7'h7F;
         else                       r[7*i +: 7] = seg_of(dig[i]);
      end
      return r;
   endfunction

   // Cycle-level behavioural model: phase 0 idle, 1 converting, 2 result edge.
   int          m_phase;
   int          m_cnt;
   logic [31:0] m_cur;
   logic        m_pv;
   logic [31:0] m_pend;
   logic [55:0] m_hex;
   logic        m_ovf;

   always @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_cnt   = 0;
         m_pv    = 1'b0;
         m_hex   = {8{7'h7F}};
         m_ovf   = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (load) begin
                  m_cur = value; m_cnt = 0; m_phase = 1;
               end
            end
            1: begin
               m_cnt = m_cnt + 1;
               if (load) begin
                  m_pend = value; m_pv = 1'b1;
               end
               if (m_cnt == 32) m_phase = 2;
            end
            default: begin
               m_hex = model_hex(m_cur, BLANK_LZ);
               m_ovf = (m_cur > 32'd99999999);
               if (load) begin
                  m_cur = value; m_pv = 1'b0; m_cnt = 0; m_phase = 1;
               end else if (m_pv) begin
                  m_cur = m_pend; m_pv = 1'b0; m_cnt = 0; m_phase = 1;
               end else begin
                  m_phase = 0;
               end
            end
         endcase
      end
   end

   always @(negedge CLOCK_50) begin
      if (rst_n) begin
         vectors++;
         if ({HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== m_hex ||
             busy !== (m_phase != 0) || ovf !== m_ovf) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t hex=%h busy=%b ovf=%b expected hex=%h busy=%b ovf=%b",
                     $time, {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, busy, ovf,
                     m_hex, (m_phase != 0), m_ovf);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic pulse(input logic [31:0] v);
      value = v;
      load  = 1'b1;
      step(1);
      load  = 1'b0;
   endtask

   function automatic logic [55:0] hexv();
      return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
   endfunction

   initial begin
      int budget;
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = '0;
      BLANK_LZ = 1'b1;
      step(3);
      rst_n = 1'b1;
      step(1);

      // Model pinned against hand-derived patterns.
      check("model_12345", model_hex(32'd12345, 1'b1),
            {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      check("model_zero_noblank", model_hex(32'd0, 1'b0), {8{7'h40}});
      check("model_ovf", model_hex(32'd100000000, 1'b1), {8{7'h3F}});

      check("reset_hex", hexv(), {8{7'h7F}});
      check("reset_busy_ovf", {busy, ovf}, 2'b00);

      // Reset mid-conversion discards everything.
      pulse(32'd12345);
      check("busy_after_load", busy, 1'b1);
      step(10);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      check("midreset_hex", hexv(), {8{7'h7F}});
      check("midreset_busy_ovf", {busy, ovf}, 2'b00);
      pulse(32'd7);
      step(33);
      check("after_reset_7", hexv(), {{7{7'h7F}}, 7'h78});

      pulse(32'd12345);
      step(32);
      check("busy_at_e32", busy, 1'b1);
      step(1);
      check("val_12345", hexv(), {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      check("val_12345_busy_ovf", {busy, ovf}, 2'b00);

      pulse(32'd0);
      step(33);
      check("zero_blank", hexv(), {{7{7'h7F}}, 7'h40});
      BLANK_LZ = 1'b0;
      pulse(32'd0);
      step(33);
      check("zero_noblank", hexv(), {8{7'h40}});
      BLANK_LZ = 1'b1;

      pulse(32'd99999999);
      step(33);
      check("max_nines", hexv(), {8{7'h10}});
      check("max_nines_ovf", ovf, 1'b0);
      pulse(32'd100000000);
      step(33);
      check("first_ovf", hexv(), {8{7'h3F}});
      check("first_ovf_flag", ovf, 1'b1);
      pulse(32'h88000000);
      step(33);
      check("big_ovf", hexv(), {8{7'h3F}});
      check("big_ovf_flag", ovf, 1'b1);

      // Loads during a conversion: newest pending one replays with no idle gap.
      pulse(32'd5);
      step(4);
      pulse(32'd42);
      step(4);
      pulse(32'd9);
      step(23);
      check("b2b_first", hexv(), {{7{7'h7F}}, 7'h12});
      check("b2b_busy_held", {busy, ovf}, 2'b10);
      step(33);
      check("b2b_final", hexv(), {{7{7'h7F}}, 7'h10});
      check("b2b_idle", busy, 1'b0);

      // Randomised traffic checked every cycle by the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 199) == 0) BLANK_LZ = ~BLANK_LZ;
         if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 4))
               0: value = $urandom_range(0, 99);
               1: value = $urandom_range(99999990, 100000010);
               2: value = $urandom_range(0, 99999999);
               default: value = $urandom;
            endcase
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
         if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
         step(1);
         rst_n = 1'b1;
      end
      load = 1'b0;
      budget = 0;
      while (busy && budget < 100) begin
         step(1);
         budget++;
      end
      check("drain_busy", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
